// File: rtl/cla_pipe_32bit.sv
// cla_pipe_32bit: two-stage pipelined 32-bit add/subtract built from two 16-bit carry-lookahead adders.
// The low half is added in stage 1 and the high half in stage 2; valid/ready handshakes sit on both sides.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  // Returns the carry out of each bit of a 4-bit lookahead block.
  function automatic logic [3:0] la(input logic [3:0] g, input logic [3:0] p, input logic c);
    logic [3:0] r;
    r[0] = g[0] | p[0] & c;
    r[1] = g[1] | p[1] & g[0] | p[1] & p[0] & c;
    r[2] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c;
    r[3] = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0] | &p & c;
    return r;
  endfunction
  logic [15:0] g, p, c;
  logic [3:0] gg, gp, gc, cc;
  assign g = a & b;
  assign p = a ^ b;
  for (genvar j = 0; j < 4; j++) begin : grp
    logic [3:0] t;
    assign t = la(g[4*j +: 4], p[4*j +: 4], 1'b0);
    assign gg[j] = t[3];
    assign gp[j] = &p[4*j +: 4];
    assign c[4*j +: 4] = la(g[4*j +: 4], p[4*j +: 4], cc[j]);
  end
  // Second lookahead level resolves all group carries at once.
  assign gc = la(gg, gp, cin);
  assign cc = {gc[2:0], cin};
  assign sum = p ^ {c[14:0], cin};
  assign cout = gc[3];
endmodule

module cla_pipe_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);
  logic [31:0] b_eff;
  logic c0, adv;
  logic [15:0] lo_sum, hi_sum;
  logic lo_c, hi_c;
  logic s1_valid, s1_c16;
  logic [15:0] s1_sum_lo, s1_a_hi, s1_b_hi;
  logic s2_valid, s2_cout, s2_ovf;
  logic [31:0] s2_sum;
  assign b_eff = sub ? ~b : b;
  assign c0 = sub ? 1'b1 : cin;
  assign adv = !s2_valid || out_ready;
  // Stage 1 also accepts while stage 2 is stalled, so two beats can be buffered.
  assign in_ready = !s1_valid || adv;
  cla_16bit u_lo (.a(a[15:0]), .b(b_eff[15:0]), .cin(c0), .sum(lo_sum), .cout(lo_c));
  cla_16bit u_hi (.a(s1_a_hi), .b(s1_b_hi), .cin(s1_c16), .sum(hi_sum), .cout(hi_c));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_c16 <= 1'b0;
      s1_sum_lo <= '0;
      s1_a_hi <= '0;
      s1_b_hi <= '0;
      s2_valid <= 1'b0;
      s2_cout <= 1'b0;
      s2_ovf <= 1'b0;
      s2_sum <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sum_lo <= lo_sum;
        s1_c16 <= lo_c;
        s1_a_hi <= a[31:16];
        s1_b_hi <= b_eff[31:16];
      end
      if (adv) s2_valid <= s1_valid;
      if (adv && s1_valid) begin
        s2_sum <= {hi_sum, s1_sum_lo};
        s2_cout <= hi_c;
        s2_ovf <= (s1_a_hi[15] == s1_b_hi[15]) && (hi_sum[15] != s1_a_hi[15]);
      end
    end
  end
  assign out_valid = s2_valid;
  assign sum = s2_sum;
  assign cout = s2_cout;
  assign ovf = s2_ovf;
endmodule
